// File: rtl/rk_pkg.sv
// Shared definitions for the RK4 step sequencer: FSM state encoding and stage indices.
package rk_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } rk_state_t;

  localparam logic [1:0] STAGE_K1 = 2'd0;
  localparam logic [1:0] STAGE_K2 = 2'd1;
  localparam logic [1:0] STAGE_K3 = 2'd2;
  localparam logic [1:0] STAGE_K4 = 2'd3;

endpackage

// File: rtl/comparator_nb.sv
// Signed n-bit magnitude comparator: exactly one of lt/eq/gt is high.
module comparator_nb #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  assign lt = $signed(a) <  $signed(b);
  assign eq = a == b;
  assign gt = $signed(a) >  $signed(b);

endmodule

// File: rtl/rk_step_sequencer.sv
// RK4 loop controller: walks x from x0 towards x_end in steps of h, issuing the
// four k-stage requests per step and committing y once all four complete.
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | compare x_cur against x_end
// ISSUE  | one-cycle stage_go for stage_sel
// WAIT   | waiting for stage_done from the datapath
// UPDATE | y_update strobe, advance x_cur by h
// DONE   | one-cycle done pulse, err valid
module rk_step_sequencer
  import rk_pkg::*;
#(
  parameter int N      = 32,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      x0,
  input  logic [N-1:0]      x_end,
  input  logic [N-1:0]      h,
  input  logic              stage_done,
  output logic              stage_go,
  output logic [1:0]        stage_sel,
  output logic [N-1:0]      stage_x,
  output logic              y_update,
  output logic [N-1:0]      x_cur,
  output logic [STEP_W-1:0] step_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  rk_state_t         state_q, state_d;
  logic [N-1:0]      x_cur_q, x_cur_d;
  logic [N-1:0]      x_end_q, x_end_d;
  logic [N-1:0]      h_q, h_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        sel_q, sel_d;
  logic              err_q, err_d;

  logic              cmp_lt, cmp_eq, cmp_gt;
  logic [N:0]        sum_ext;
  logic signed [N-1:0] h_half;

  comparator_nb #(.n(N)) u_cmp (
    .a  (x_cur_q),
    .b  (x_end_q),
    .lt (cmp_lt),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  // One extra bit so signed overflow of x_cur + h shows as sum_ext[N] != sum_ext[N-1].
  assign sum_ext = {x_cur_q[N-1], x_cur_q} + {h_q[N-1], h_q};
  assign h_half  = $signed(h_q) >>> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_cur_q <= '0;
      x_end_q <= '0;
      h_q     <= '0;
      step_q  <= '0;
      sel_q   <= STAGE_K1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_cur_q <= x_cur_d;
      x_end_q <= x_end_d;
      h_q     <= h_d;
      step_q  <= step_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_cur_d = x_cur_q;
    x_end_d = x_end_q;
    h_d     = h_q;
    step_d  = step_q;
    sel_d   = sel_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_cur_d = x0;
          x_end_d = x_end;
          h_d     = h;
          step_d  = '0;
          sel_d   = STAGE_K1;
          err_d   = 1'b0;
          if ($signed(h) <= 0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (cmp_lt) begin
          sel_d   = STAGE_K1;
          state_d = ISSUE;
        end else if (cmp_eq || cmp_gt) begin
          state_d = DONE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (stage_done) begin
          if (sel_q == STAGE_K4) begin
            state_d = UPDATE;
          end else begin
            sel_d   = sel_q + 2'd1;
            state_d = ISSUE;
          end
        end
      end
      UPDATE: begin
        if (sum_ext[N] != sum_ext[N-1]) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (&step_q) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          x_cur_d = sum_ext[N-1:0];
          step_d  = step_q + 1'b1;
          state_d = CHECK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (sel_q)
      STAGE_K1: stage_x = x_cur_q;
      STAGE_K4: stage_x = x_cur_q + h_q;
      default:  stage_x = x_cur_q + h_half;
    endcase
  end

  assign stage_go  = state_q == ISSUE;
  assign y_update  = state_q == UPDATE;
  assign done      = state_q == DONE;
  assign busy      = (state_q == CHECK) || (state_q == ISSUE) ||
                     (state_q == WAIT)  || (state_q == UPDATE);
  assign stage_sel = sel_q;
  assign x_cur     = x_cur_q;
  assign step_cnt  = step_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rk_step_sequencer.sv
// Directed bench for rk_step_sequencer with an auto-responding stage datapath model.
module tb_rk_step_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] x0 = '0, x_end = '0, h = '0;
  logic        stage_done = 1'b0;
  logic        stage_go, y_update, busy, done, err;
  logic [1:0]  stage_sel;
  logic [31:0] stage_x, x_cur;
  logic [15:0] step_cnt;

  int total = 0;
  int bad = 0;

  logic auto_resp = 1'b1;
  logic force_done = 1'b0;
  logic go_seen = 1'b0;
  int cnt_go = 0, cnt_upd = 0, cnt_done = 0;
  logic [31:0] sx[$];

  rk_step_sequencer #(.N(32), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .x_end(x_end), .h(h),
    .stage_done(stage_done), .stage_go(stage_go), .stage_sel(stage_sel),
    .stage_x(stage_x), .y_update(y_update), .x_cur(x_cur), .step_cnt(step_cnt),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Datapath model: answers stage_done in the cycle after each stage_go.
  always @(negedge clk) begin
    stage_done = (auto_resp && go_seen) || force_done;
    go_seen = stage_go;
  end

  always @(negedge clk) begin
    if (stage_go) begin
      cnt_go++;
      sx.push_back(stage_x);
    end
    if (y_update) cnt_upd++;
    if (done) cnt_done++;
  end

  task automatic clear_mon();
    @(negedge clk);
    cnt_go = 0; cnt_upd = 0; cnt_done = 0;
    sx.delete();
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    @(negedge clk);
    x0 = a; x_end = b; h = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (stage_go !== 1'b0 || y_update !== 1'b0) begin bad++; $display("FAIL reset_strobes go=%b upd=%b exp=0", stage_go, y_update); end
    total++; if (stage_sel !== 2'd0 || x_cur !== 32'd0 || step_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_regs sel=%0d x=%h step=%0d exp=0", stage_sel, x_cur, step_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit got;
    clear_mon();
    launch(32'd0, 32'd8, 32'd2);
    wait_done(got);
    total++; if (!got) begin bad++; $display("FAIL basic_timeout done not seen"); end
    total++; if (x_cur !== 32'd8 || step_cnt !== 16'd4 || err !== 1'b0) begin
      bad++; $display("FAIL basic_result x=%0d step=%0d err=%b exp x=8 step=4 err=0", x_cur, step_cnt, err);
    end
    total++; if (cnt_go !== 16 || cnt_upd !== 4) begin
      bad++; $display("FAIL basic_pulses go=%0d upd=%0d exp 16/4", cnt_go, cnt_upd);
    end
    total++; if (sx.size() < 4 || sx[0] !== 32'd0 || sx[1] !== 32'd1 || sx[2] !== 32'd1 || sx[3] !== 32'd2) begin
      bad++; $display("FAIL basic_stage_x n=%0d got=%p exp 0,1,1,2", sx.size(), sx);
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || cnt_done !== 1) begin
      bad++; $display("FAIL basic_after busy=%b done=%b ndone=%0d exp 0/0/1", busy, done, cnt_done);
    end
  endtask

  task automatic test_equal();
    clear_mon();
    launch(32'd5, 32'd5, 32'd1);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL equal_check busy=%b done=%b exp 1/0", busy, done);
    end
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL equal_done done=%b busy=%b exp 1/0", done, busy);
    end
    total++; if (err !== 1'b0 || step_cnt !== 16'd0 || x_cur !== 32'd5 || cnt_go !== 0) begin
      bad++; $display("FAIL equal_result err=%b step=%0d x=%0d go=%0d exp 0/0/5/0", err, step_cnt, x_cur, cnt_go);
    end
  endtask

  task automatic test_bad_h();
    logic [31:0] hv [2];
    bit got;
    hv[0] = 32'd0;
    hv[1] = 32'hFFFF_FFFD;
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      launch(32'd0, 32'd8, hv[k]);
      wait_done(got);
      total++; if (!got || err !== 1'b1) begin
        bad++; $display("FAIL bad_h_err h=%h got_done=%0d err=%b exp err=1", hv[k], got, err);
      end
      @(negedge clk);
      total++; if (busy !== 1'b0 || cnt_go !== 0 || err !== 1'b1) begin
        bad++; $display("FAIL bad_h_after h=%h busy=%b go=%0d err=%b exp 0/0/1", hv[k], busy, cnt_go, err);
      end
    end
  endtask

  task automatic test_negative();
    bit got;
    clear_mon();
    launch(32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'd2);
    wait_done(got);
    total++; if (!got || x_cur !== 32'd0 || step_cnt !== 16'd3 || err !== 1'b0) begin
      bad++; $display("FAIL neg_result got_done=%0d x=%h step=%0d err=%b exp x=0 step=3 err=0", got, x_cur, step_cnt, err);
    end
    total++; if (cnt_go !== 12 || sx[0] !== 32'hFFFF_FFFA || sx[4] !== 32'hFFFF_FFFC || sx[8] !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL neg_steps go=%0d got=%p exp -6,-4,-2 at k1", cnt_go, sx);
    end
  endtask

  task automatic test_overflow();
    bit got;
    clear_mon();
    launch(32'h7FFF_FFF0, 32'h7FFF_FFFF, 32'd16);
    wait_done(got);
    total++; if (!got || err !== 1'b1 || x_cur !== 32'h7FFF_FFF0 || step_cnt !== 16'd0) begin
      bad++; $display("FAIL ovf_result got_done=%0d err=%b x=%h step=%0d exp 1/7ffffff0/0", got, err, x_cur, step_cnt);
    end
    total++; if (cnt_go !== 4 || cnt_upd !== 1) begin
      bad++; $display("FAIL ovf_pulses go=%0d upd=%0d exp 4/1", cnt_go, cnt_upd);
    end
  endtask

  task automatic test_abort_restart();
    bit got;
    bit hit;
    clear_mon();
    launch(32'd0, 32'd8, 32'd2);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (stage_go && step_cnt == 16'd1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    auto_resp = 1'b0;
    total++; if (!hit) begin bad++; $display("FAIL abort_reach step 2 issue not seen"); end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1 || x_cur !== 32'd2 || stage_sel !== 2'd0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_start_ignored busy=%b x=%0d sel=%0d done=%b exp 1/2/0/0", busy, x_cur, stage_sel, done);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || x_cur !== 32'd0 || step_cnt !== 16'd0 || stage_sel !== 2'd0) begin
      bad++; $display("FAIL abort_reset busy=%b done=%b err=%b x=%0d step=%0d sel=%0d exp all 0", busy, done, err, x_cur, step_cnt, stage_sel);
    end
    force_done = 1'b1;
    repeat (3) @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || cnt_done !== 0 || stage_go !== 1'b0) begin
      bad++; $display("FAIL abort_idle busy=%b ndone=%0d go=%b exp 0/0/0", busy, cnt_done, stage_go);
    end
    auto_resp = 1'b1;
    clear_mon();
    launch(32'd0, 32'd8, 32'd2);
    wait_done(got);
    total++; if (!got || x_cur !== 32'd8 || step_cnt !== 16'd4 || err !== 1'b0 || cnt_go !== 16) begin
      bad++; $display("FAIL restart_result got_done=%0d x=%0d step=%0d err=%b go=%0d exp 8/4/0/16", got, x_cur, step_cnt, err, cnt_go);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_equal();
    test_bad_h();
    test_negative();
    test_overflow();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
